// File: rtl/rti_unit.sv
// rti_unit: return-from-interrupt sequencer.
// On a decoded RTI it stalls fetch and pops PCH (id 9), PCL (id 8) and CCR (id 10).
// It collects the returned words in any order, then issues a one-cycle branch to
// the restored PC together with a CCR restore strobe.
// Optional feature: define RTI_TIMEOUT_EN to abort a stuck collect phase after
// TIMEOUT_CYCLES cycles. The abort pulses rti_error and issues no branch.
module rti_unit #(
  parameter int DATA_W         = 16,
  parameter int CCR_W          = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                rti_req,
  input  logic                mem_valid,
  input  logic [3:0]          mem_reg_id,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                stall,
  output logic                stack_op,
  output logic                push_pop,
  output logic [3:0]          reg_id,
  output logic                branch,
  output logic [2*DATA_W-1:0] PC_VALUE,
  output logic                ccr_load,
  output logic [CCR_W-1:0]    ccr_value,
  output logic                done,
  output logic                rti_error
);

  localparam logic [3:0] ID_PCL = 4'd8;
  localparam logic [3:0] ID_PCH = 4'd9;
  localparam logic [3:0] ID_CCR = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STALL   = 3'd1,
    ST_POP_PCH = 3'd2,
    ST_POP_PCL = 3'd3,
    ST_POP_CCR = 3'd4,
    ST_COLLECT = 3'd5,
    ST_BRANCH  = 3'd6
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  // Received mask: bit 0 = PCH, bit 1 = PCL, bit 2 = CCR.
  logic [2:0]          mask_r;
  logic [2:0]          cap_s;
  logic [2:0]          mask_nxt_s;
  logic                complete_s;
  logic                tmo_hit_s;
  logic                tmo_s;
  logic [DATA_W-1:0]   pc_hi_r;
  logic [DATA_W-1:0]   pc_lo_r;
  logic [CCR_W-1:0]    ccr_r;

  // The stack is only ever popped by this block.
  assign push_pop  = 1'b0;
  assign PC_VALUE  = {pc_hi_r, pc_lo_r};
  assign ccr_value = ccr_r;

  // Capture strobes. Only the first word per slot is taken, and only while a sequence runs.
  always_comb begin
    cap_s = 3'b000;
    if (enable && (state_r != ST_IDLE) && mem_valid) begin
      case (mem_reg_id)
        ID_PCH:  cap_s[0] = ~mask_r[0];
        ID_PCL:  cap_s[1] = ~mask_r[1];
        ID_CCR:  cap_s[2] = ~mask_r[2];
        default: cap_s    = 3'b000;
      endcase
    end else begin
      cap_s = 3'b000;
    end
  end

  assign mask_nxt_s = mask_r | cap_s;
  assign complete_s = &mask_nxt_s;

`ifdef RTI_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_r;

  assign tmo_hit_s = (tmo_cnt_r == CNT_LAST);

  // Collect-phase watchdog: zero on entry to COLLECT, counts each incomplete COLLECT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_COLLECT) && (state_nxt_s == ST_COLLECT)) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state decision, including the enable override and the collect timeout.
  always_comb begin
    state_nxt_s = state_r;
    tmo_s       = 1'b0;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = rti_req ? ST_STALL : ST_IDLE;
        ST_STALL:   state_nxt_s = ST_POP_PCH;
        ST_POP_PCH: state_nxt_s = ST_POP_PCL;
        ST_POP_PCL: state_nxt_s = ST_POP_CCR;
        ST_POP_CCR: state_nxt_s = complete_s ? ST_BRANCH : ST_COLLECT;
        ST_COLLECT: begin
          if (complete_s) begin
            state_nxt_s = ST_BRANCH;
          end else if (tmo_hit_s) begin
            state_nxt_s = ST_IDLE;
            tmo_s       = 1'b1;
          end else begin
            state_nxt_s = ST_COLLECT;
          end
        end
        ST_BRANCH:  state_nxt_s = ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register plus control outputs registered from the next state, so they are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      stall     <= 1'b0;
      stack_op  <= 1'b0;
      reg_id    <= 4'd0;
      branch    <= 1'b0;
      ccr_load  <= 1'b0;
      done      <= 1'b0;
      rti_error <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      stall     <= (state_nxt_s != ST_IDLE);
      branch    <= (state_nxt_s == ST_BRANCH);
      ccr_load  <= (state_nxt_s == ST_BRANCH);
      done      <= (state_nxt_s == ST_BRANCH);
      rti_error <= tmo_s;
      case (state_nxt_s)
        ST_POP_PCH: begin
          stack_op <= 1'b1;
          reg_id   <= ID_PCH;
        end
        ST_POP_PCL: begin
          stack_op <= 1'b1;
          reg_id   <= ID_PCL;
        end
        ST_POP_CCR: begin
          stack_op <= 1'b1;
          reg_id   <= ID_CCR;
        end
        default: begin
          stack_op <= 1'b0;
          reg_id   <= 4'd0;
        end
      endcase
    end
  end

  // Popped-word capture. The mask clears whenever the sequence returns to IDLE; data holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r  <= 3'b000;
      pc_hi_r <= {DATA_W{1'b0}};
      pc_lo_r <= {DATA_W{1'b0}};
      ccr_r   <= {CCR_W{1'b0}};
    end else begin
      if (state_nxt_s == ST_IDLE) begin
        mask_r <= 3'b000;
      end else begin
        mask_r <= mask_nxt_s;
      end
      if (cap_s[0]) begin
        pc_hi_r <= mem_data;
      end
      if (cap_s[1]) begin
        pc_lo_r <= mem_data;
      end
      if (cap_s[2]) begin
        ccr_r <= mem_data[CCR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rti_unit.sv
// Self-checking bench for rti_unit: directed scenarios followed by randomized traffic.
// The reference model tracks the sequence as a cycle position and a set of
// received stack ids. It also follows RTI_TIMEOUT_EN.
module tb_rti_unit;

  localparam int DW  = 16;
  localparam int CW  = 3;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          rti_req;
  logic          mem_valid;
  logic [3:0]    mem_reg_id;
  logic [DW-1:0] mem_data;
  logic          stall;
  logic          stack_op;
  logic          push_pop;
  logic [3:0]    reg_id;
  logic          branch;
  logic [2*DW-1:0] PC_VALUE;
  logic          ccr_load;
  logic [CW-1:0] ccr_value;
  logic          done;
  logic          rti_error;

  always #5 clk = ~clk;

  rti_unit #(.DATA_W(DW), .CCR_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rti_req(rti_req),
    .mem_valid(mem_valid), .mem_reg_id(mem_reg_id), .mem_data(mem_data),
    .stall(stall), .stack_op(stack_op), .push_pop(push_pop), .reg_id(reg_id),
    .branch(branch), .PC_VALUE(PC_VALUE), .ccr_load(ccr_load),
    .ccr_value(ccr_value), .done(done), .rti_error(rti_error)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_br  = 0;
  int n_err = 0;

  // Reference model state.
  bit          m_active;   // a sequence is running (STALL onward)
  bit          m_branch;   // this cycle is the branch cycle
  bit          m_err;      // timeout pulse this cycle
  int          m_pos;      // 0 = stall, 1..3 = pops, 4 = collecting
  int          m_ccnt;     // collect cycles spent incomplete
  bit [2:0]    m_got;      // 0 = PCH, 1 = PCL, 2 = CCR
  logic [31:0] m_pc;
  logic [2:0]  m_ccr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int item_of(input logic [3:0] id);
    if (id == 4'd9) return 0;
    else if (id == 4'd8) return 1;
    else if (id == 4'd10) return 2;
    else return -1;
  endfunction

  function automatic logic [3:0] pop_id(input int pos);
    if (pos == 1) return 4'd9;
    else if (pos == 2) return 4'd8;
    else return 4'd10;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_branch = 1'b0; m_err = 1'b0;
    m_pos = 0; m_ccnt = 0; m_got = 3'b000;
    m_pc = 32'h0; m_ccr = 3'b000;
  endtask

  // Advance the model over one rising edge using the inputs presented in the cycle.
  task automatic model_edge();
    bit err_n;
    int it;
    err_n = 1'b0;
    if (!enable) begin
      m_active = 1'b0; m_branch = 1'b0; m_got = 3'b000;
    end else if (m_branch) begin
      m_active = 1'b0; m_branch = 1'b0; m_got = 3'b000;
    end else if (!m_active) begin
      if (rti_req) begin
        m_active = 1'b1; m_pos = 0;
      end
    end else begin
      if (mem_valid) begin
        it = item_of(mem_reg_id);
        if (it >= 0 && !m_got[it]) begin
          m_got[it] = 1'b1;
          if (it == 0) m_pc[31:16] = mem_data;
          else if (it == 1) m_pc[15:0] = mem_data;
          else m_ccr = mem_data[2:0];
        end
      end
      if (m_pos < 3) begin
        m_pos++;
      end else if (m_got == 3'b111) begin
        m_branch = 1'b1;
      end else if (m_pos == 3) begin
        m_pos = 4; m_ccnt = 0;
      end else begin
`ifdef RTI_TIMEOUT_EN
        if (m_ccnt + 1 == TMO) begin
          m_active = 1'b0; m_got = 3'b000; err_n = 1'b1;
        end else begin
          m_ccnt++;
        end
`endif
      end
    end
    m_err = err_n;
  endtask

  task automatic check_outputs();
    bit pop;
    logic [3:0] rid;
    pop = m_active && !m_branch && (m_pos >= 1) && (m_pos <= 3);
    rid = pop ? pop_id(m_pos) : 4'd0;
    check("stall", 32'(stall), 32'(m_active));
    check("stack_op", 32'(stack_op), 32'(pop));
    check("push_pop", 32'(push_pop), 32'(0));
    check("reg_id", 32'(reg_id), 32'(rid));
    check("branch", 32'(branch), 32'(m_branch));
    check("ccr_load", 32'(ccr_load), 32'(m_branch));
    check("done", 32'(done), 32'(m_branch));
    check("rti_error", 32'(rti_error), 32'(m_err));
    if (m_branch) begin
      check("pc_value", PC_VALUE, m_pc);
      check("ccr_value", 32'(ccr_value), 32'(m_ccr));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (branch) n_br++;
    if (rti_error) n_err++;
  endtask

  task automatic drive(input logic req, input logic mv, input logic [3:0] id, input logic [15:0] d);
    rti_req = req; mem_valid = mv; mem_reg_id = id; mem_data = d;
    tick();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check_outputs();
    check("rst_pc", PC_VALUE, 32'h0);
    check("rst_ccr", 32'(ccr_value), 32'(0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; rti_req = 1'b0;
    mem_valid = 1'b0; mem_reg_id = 4'd0; mem_data = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("init_pc", PC_VALUE, 32'h0);
    @(negedge clk);
    reset = 1'b1; enable = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 16'h0);

    // Reset mid-COLLECT, then a stray id 9 word in IDLE must not be captured.
    drive(1'b1, 1'b0, 4'd0, 16'h0);
    repeat (5) drive(1'b0, 1'b0, 4'd0, 16'h0);
    async_reset();
    drive(1'b0, 1'b1, 4'd9, 16'hABCD);
    check("t1_no_capture", PC_VALUE, 32'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);

    // In-order words starting at POP_PCL.
    n_br = 0;
    drive(1'b1, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    check("t2_reg_id_pcl", 32'(reg_id), 32'(8));
    drive(1'b0, 1'b1, 4'd9, 16'h0001);
    drive(1'b0, 1'b1, 4'd8, 16'h2345);
    drive(1'b0, 1'b1, 4'd10, 16'h0005);
    check("t2_branch", 32'(branch), 32'(1));
    check("t2_pc", PC_VALUE, 32'h00012345);
    check("t2_ccr", 32'(ccr_value), 32'(3'b101));
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    check("t2_branch_pulses", 32'(n_br), 32'(1));
    check("t2_pc_held", PC_VALUE, 32'h00012345);

    // Out of order 10, 8, gap, duplicate 8, then 9.
    n_br = 0;
    drive(1'b1, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b1, 4'd10, 16'h0002);
    drive(1'b0, 1'b1, 4'd8, 16'h1111);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b1, 4'd8, 16'hFFFF);
    check("t3_no_early_branch", 32'(branch), 32'(0));
    drive(1'b0, 1'b1, 4'd9, 16'h0ABC);
    check("t3_branch", 32'(branch), 32'(1));
    check("t3_pc", PC_VALUE, 32'h0ABC1111);
    check("t3_ccr", 32'(ccr_value), 32'(3'b010));
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    check("t3_branch_pulses", 32'(n_br), 32'(1));

    // Second request during POP_PCL is ignored; enable drop in COLLECT aborts.
    n_br = 0;
    drive(1'b1, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b1, 1'b1, 4'd9, 16'h1234);
    drive(1'b0, 1'b1, 4'd8, 16'h5678);
    check("t4_in_collect", 32'(stall), 32'(1));
    enable = 1'b0;
    drive(1'b0, 1'b1, 4'd10, 16'h0003);
    check("t4_idle_stall", 32'(stall), 32'(0));
    enable = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 4'd0, 16'h0);
    check("t4_no_branch", 32'(n_br), 32'(0));

    // Only PCH and PCL returned: timeout when enabled, otherwise wait forever.
    n_br = 0; n_err = 0;
    drive(1'b1, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 1'b1, 4'd9, 16'h00AA);
    drive(1'b0, 1'b1, 4'd8, 16'h00BB);
    repeat (12) drive(1'b0, 1'b0, 4'd0, 16'h0);
    check("t5_no_branch", 32'(n_br), 32'(0));
`ifdef RTI_TIMEOUT_EN
    check("t5_err_pulses", 32'(n_err), 32'(1));
    check("t5_idle", 32'(stall), 32'(0));
`else
    check("t5_err_pulses", 32'(n_err), 32'(0));
    check("t5_still_collect", 32'(stall), 32'(1));
`endif
    enable = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    enable = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      enable = ($urandom_range(0, 31) != 0);
      sel = int'($urandom_range(0, 5));
      if (sel == 0) mem_reg_id = 4'd9;
      else if (sel == 1) mem_reg_id = 4'd8;
      else if (sel == 2) mem_reg_id = 4'd10;
      else mem_reg_id = 4'($urandom_range(0, 15));
      rti_req = ($urandom_range(0, 3) == 0);
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_data = 16'($urandom_range(0, 65535));
      tick();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
